// File: rtl/xx02_mm_arb_pkg.sv
// xx02_mm_arb_pkg: shared types and constants for the xx02 memory-mapped bus
// arbiter.
//   state_t         : arbiter FSM states (IDLE, ISSUE, WAIT_RD)
//   req_id_t        : requester identity (REQ_A = PCIe BAR, REQ_B = debug/sequencer)
//   TIMEOUT_PATTERN : upper word of the data returned when a read times out
package xx02_mm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_0BAD;

endpackage

// File: rtl/xx02_rr_arb2.sv
// xx02_rr_arb2: two-way round-robin grant decision (purely combinational).
// Ports:
//   i_req[1:0]    in  request vector, bit 0 = requester A, bit 1 = requester B
//   i_last_grant  in  requester granted most recently
//   o_gnt_v       out some requester is granted
//   o_gnt_id      out granted requester (valid when o_gnt_v)
module xx02_rr_arb2
  import xx02_mm_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_id_t    i_last_grant,
  output logic       o_gnt_v,
  output req_id_t    o_gnt_id
);

  always_comb begin
    o_gnt_v  = |i_req;
    o_gnt_id = REQ_A;
    case (i_req)
      2'b01:   o_gnt_id = REQ_A;
      2'b10:   o_gnt_id = REQ_B;
      // tie: the requester that did not win last time goes first
      2'b11:   o_gnt_id = (i_last_grant == REQ_A) ? REQ_B : REQ_A;
      default: o_gnt_id = REQ_A;
    endcase
  end

endmodule

// File: rtl/xx02_mm_arbiter.sv
// xx02_mm_arbiter: shares the xx02 register bus between requester A (PCIe BAR
// target) and requester B (debug/sequencer). One transaction in flight at a
// time; read data is routed back to the requester that issued the read.
//
// Optional build macro: MM_ARB_TIMEOUT_EN
//   defined   : a read with no response for TO_CYCLES cycles (counted from the
//               issue cycle) returns {DEAD_0BAD, 0.., addr} and bumps timeout_cnt
//   undefined : WAIT_RD waits indefinitely; timeout_cnt is tied to 0
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   a_/b_addr, _wr_en, _rd_en,       requester side request (level, held until ack)
//   a_/b_wr_data
//   a_/b_ack                         request issued, 1-cycle pulse
//   a_/b_rd_data, _rd_data_v         read return data and 1-cycle valid
//   m_addr, m_wr_en, m_rd_en,        decoder side command
//   m_wr_data
//   m_rd_data, m_rd_data_v           decoder read return
//   busy                             transaction in flight
//   timeout_cnt                      saturating count of read timeouts
module xx02_mm_arbiter
  import xx02_mm_arb_pkg::*;
#(
  parameter int AW        = 14,
  parameter int DW        = 64,
  parameter int TO_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_wr_en,
  input  logic          a_rd_en,
  input  logic [DW-1:0] a_wr_data,
  output logic          a_ack,
  output logic [DW-1:0] a_rd_data,
  output logic          a_rd_data_v,
  input  logic [AW-1:0] b_addr,
  input  logic          b_wr_en,
  input  logic          b_rd_en,
  input  logic [DW-1:0] b_wr_data,
  output logic          b_ack,
  output logic [DW-1:0] b_rd_data,
  output logic          b_rd_data_v,
  output logic [AW-1:0] m_addr,
  output logic          m_wr_en,
  output logic          m_rd_en,
  output logic [DW-1:0] m_wr_data,
  input  logic [DW-1:0] m_rd_data,
  input  logic          m_rd_data_v,
  output logic          busy,
  output logic [15:0]   timeout_cnt
);

  state_t        r_state;
  state_t        w_state_nxt;
  req_id_t       r_last_grant;
  req_id_t       r_owner;
  logic          r_is_rd;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wr_data;
  logic          r_m_wr_en;
  logic          r_m_rd_en;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rd_data;
  logic [DW-1:0] r_b_rd_data;
  logic          r_a_rd_data_v;
  logic          r_b_rd_data_v;
  logic          r_busy;

  logic [1:0]    w_req;
  logic          w_gnt_v;
  req_id_t       w_gnt_id;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_data;
  logic          w_sel_wr;
  logic          w_grant;
  logic          w_timeout;
  logic          w_rd_done;
  logic [DW-1:0] w_to_data;
  logic [DW-1:0] w_rd_word;

  assign w_req = {b_wr_en | b_rd_en, a_wr_en | a_rd_en};

  xx02_rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_gnt_v      (w_gnt_v),
    .o_gnt_id     (w_gnt_id)
  );

  // write wins when a requester raises both enables
  assign w_sel_addr = (w_gnt_id == REQ_A) ? a_addr    : b_addr;
  assign w_sel_data = (w_gnt_id == REQ_A) ? a_wr_data : b_wr_data;
  assign w_sel_wr   = (w_gnt_id == REQ_A) ? a_wr_en   : b_wr_en;

  assign w_grant   = (r_state == IDLE) && w_gnt_v;
  assign w_rd_done = (r_state == WAIT_RD) && (m_rd_data_v || w_timeout);

  // m_addr still holds the address of the outstanding read
  assign w_to_data = {TIMEOUT_PATTERN, {(32-AW){1'b0}}, r_m_addr};
  // real data takes priority over a coincident timeout
  assign w_rd_word = m_rd_data_v ? m_rd_data : w_to_data;

`ifdef MM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic [15:0]   r_timeout_cnt;

  // zero during IDLE so it reads 0 in the ISSUE cycle: timeout counts from issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state == IDLE) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_timeout = (r_state == WAIT_RD) && (r_timer == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_cnt <= 16'h0000;
    end else if (w_timeout && !m_rd_data_v && (r_timeout_cnt != 16'hFFFF)) begin
      r_timeout_cnt <= r_timeout_cnt + 16'h0001;
    end
  end

  assign timeout_cnt = r_timeout_cnt;
`else
  logic w_unused_to_cycles;
  assign w_unused_to_cycles = (TO_CYCLES > 0);
  assign w_timeout   = 1'b0;
  assign timeout_cnt = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_v) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = r_is_rd ? WAIT_RD : IDLE;
      WAIT_RD: if (m_rd_data_v || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command, ack and return registers. Pulses default low each cycle; the
  // command fields are loaded on the grant edge so they are valid in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant  <= REQ_B;
      r_owner       <= REQ_A;
      r_is_rd       <= 1'b0;
      r_m_addr      <= '0;
      r_m_wr_data   <= '0;
      r_m_wr_en     <= 1'b0;
      r_m_rd_en     <= 1'b0;
      r_a_ack       <= 1'b0;
      r_b_ack       <= 1'b0;
      r_a_rd_data   <= '0;
      r_b_rd_data   <= '0;
      r_a_rd_data_v <= 1'b0;
      r_b_rd_data_v <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_m_wr_en     <= 1'b0;
      r_m_rd_en     <= 1'b0;
      r_a_ack       <= 1'b0;
      r_b_ack       <= 1'b0;
      r_a_rd_data_v <= 1'b0;
      r_b_rd_data_v <= 1'b0;
      r_busy        <= (w_state_nxt != IDLE);
      if (w_grant) begin
        r_m_addr     <= w_sel_addr;
        r_m_wr_data  <= w_sel_data;
        r_m_wr_en    <= w_sel_wr;
        r_m_rd_en    <= !w_sel_wr;
        r_is_rd      <= !w_sel_wr;
        r_a_ack      <= (w_gnt_id == REQ_A);
        r_b_ack      <= (w_gnt_id == REQ_B);
        r_last_grant <= w_gnt_id;
        r_owner      <= w_gnt_id;
      end
      if (w_rd_done) begin
        if (r_owner == REQ_A) begin
          r_a_rd_data   <= w_rd_word;
          r_a_rd_data_v <= 1'b1;
        end else begin
          r_b_rd_data   <= w_rd_word;
          r_b_rd_data_v <= 1'b1;
        end
      end
    end
  end

  assign m_addr      = r_m_addr;
  assign m_wr_data   = r_m_wr_data;
  assign m_wr_en     = r_m_wr_en;
  assign m_rd_en     = r_m_rd_en;
  assign a_ack       = r_a_ack;
  assign b_ack       = r_b_ack;
  assign a_rd_data   = r_a_rd_data;
  assign b_rd_data   = r_b_rd_data;
  assign a_rd_data_v = r_a_rd_data_v;
  assign b_rd_data_v = r_b_rd_data_v;
  assign busy        = r_busy;

endmodule

// File: tb/tb_xx02_mm_arbiter.sv
// tb_xx02_mm_arbiter: scoreboard bench for xx02_mm_arbiter. Stimulus queues
// transactions per requester and pushes the expected bus issues / read returns
// (ordered by the round-robin rule) into scoreboard queues; a monitor compares
// whatever the DUT presents. A responder process plays the register decoder.
module tb_xx02_mm_arbiter;

  localparam int TO_CYCLES = 64;

  typedef struct {
    logic        wr;
    logic        rd_also;
    logic [13:0] addr;
    logic [63:0] data;
  } txn_t;

  typedef struct {
    bit          id;
    logic        wr;
    logic [13:0] addr;
    logic [63:0] data;
  } iss_t;

  typedef struct {
    bit          id;
    logic [63:0] data;
  } rd_t;

  typedef struct {
    int          delay;
    logic [63:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] a_addr = '0, b_addr = '0;
  logic        a_wr_en = 1'b0, a_rd_en = 1'b0, b_wr_en = 1'b0, b_rd_en = 1'b0;
  logic [63:0] a_wr_data = '0, b_wr_data = '0;
  logic        a_ack, b_ack, a_rd_data_v, b_rd_data_v;
  logic [63:0] a_rd_data, b_rd_data;
  logic [13:0] m_addr;
  logic        m_wr_en, m_rd_en;
  logic [63:0] m_wr_data;
  logic [63:0] m_rd_data = '0;
  logic        m_rd_data_v = 1'b0;
  logic        busy;
  logic [15:0] timeout_cnt;

  xx02_mm_arbiter #(.AW(14), .DW(64), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_addr(a_addr), .a_wr_en(a_wr_en), .a_rd_en(a_rd_en), .a_wr_data(a_wr_data),
    .a_ack(a_ack), .a_rd_data(a_rd_data), .a_rd_data_v(a_rd_data_v),
    .b_addr(b_addr), .b_wr_en(b_wr_en), .b_rd_en(b_rd_en), .b_wr_data(b_wr_data),
    .b_ack(b_ack), .b_rd_data(b_rd_data), .b_rd_data_v(b_rd_data_v),
    .m_addr(m_addr), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data), .m_rd_data_v(m_rd_data_v),
    .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  txn_t  a_q[$], b_q[$];
  iss_t  exp_iss[$];
  rd_t   exp_rd[$];
  resp_t resp_q[$];
  bit    tb_last = 1'b1;       // model of last grant: B out of reset
  bit    resp_busy = 1'b0;
  int    last_issue_cyc = 0;
  int    rd_lat = 0;
  bit    chk_gap = 1'b0;
  bit    gap_armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not expected or bound expired", name);
  endtask

  function automatic logic ack_of(input bit id);
    return id ? b_ack : a_ack;
  endfunction

  task automatic set_req(input bit id, input logic wr, input logic rd,
                         input logic [13:0] addr, input logic [63:0] data);
    if (!id) begin
      a_wr_en = wr; a_rd_en = rd; a_addr = addr; a_wr_data = data;
    end else begin
      b_wr_en = wr; b_rd_en = rd; b_addr = addr; b_wr_data = data;
    end
  endtask

  task automatic queue_txn(input bit id, input logic wr, input logic rd_also,
                           input logic [13:0] addr, input logic [63:0] data);
    txn_t t;
    t.wr = wr; t.rd_also = rd_also; t.addr = addr; t.data = data;
    if (!id) a_q.push_back(t); else b_q.push_back(t);
  endtask

  // expected issue; for reads, also the decoder behaviour and the return
  task automatic expect_txn(input bit id, input logic wr, input logic [13:0] addr,
                            input logic [63:0] data, input int delay,
                            input logic [63:0] rdata, input bit deliver,
                            input logic [63:0] exp_rdata);
    iss_t  i;
    rd_t   r;
    resp_t s;
    i.id = id; i.wr = wr; i.addr = addr; i.data = data;
    exp_iss.push_back(i);
    if (!wr) begin
      s.delay = delay; s.data = rdata;
      resp_q.push_back(s);
      if (deliver) begin
        r.id = id; r.data = exp_rdata;
        exp_rd.push_back(r);
      end
    end
    tb_last = id;
  endtask

  task automatic drive_req(input bit id);
    txn_t t;
    int   w;
    bit   more;
    more = id ? (b_q.size() > 0) : (a_q.size() > 0);
    while (more) begin
      if (!id) t = a_q.pop_front(); else t = b_q.pop_front();
      set_req(id, t.wr, !t.wr || t.rd_also, t.addr, t.data);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!ack_of(id) && w < 3000);
      if (!ack_of(id)) begin
        fail(id ? "b_ack_wait" : "a_ack_wait");
        set_req(id, 1'b0, 1'b0, '0, '0);
        return;
      end
      more = id ? (b_q.size() > 0) : (a_q.size() > 0);
    end
    set_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_iss.size() > 0 || exp_rd.size() > 0 || resp_busy || busy) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) fail("drain_wait");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acks_valids"}, {a_ack, b_ack, a_rd_data_v, b_rd_data_v, m_wr_en, m_rd_en, busy}, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wr_data"}, m_wr_data, 0);
    check({tag, "_a_rd_data"}, a_rd_data, 0);
    check({tag, "_b_rd_data"}, b_rd_data, 0);
    check({tag, "_timeout_cnt"}, timeout_cnt, 0);
  endtask

  // decoder model: answers each read after the scheduled delay (delay < 0: never)
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && m_rd_en) begin
        if (resp_q.size() == 0) begin
          fail("resp_underflow");
        end else begin
          r = resp_q.pop_front();
          if (r.delay > 0) begin
            resp_busy = 1'b1;
            repeat (r.delay) @(negedge clk);
            m_rd_data   = r.data;
            m_rd_data_v = 1'b1;
            @(negedge clk);
            m_rd_data_v = 1'b0;
            resp_busy   = 1'b0;
          end
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    iss_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (m_wr_en || m_rd_en) begin
        if (exp_iss.size() == 0) begin
          fail("unexpected_issue");
        end else begin
          e = exp_iss.pop_front();
          check("issue_a_ack", a_ack, !e.id);
          check("issue_b_ack", b_ack, e.id);
          check("issue_wr_en", m_wr_en, e.wr);
          check("issue_rd_en", m_rd_en, !e.wr);
          check("issue_addr", m_addr, e.addr);
          if (e.wr) check("issue_wr_data", m_wr_data, e.data);
        end
        if (chk_gap && gap_armed) check("write_gap", cyc - last_issue_cyc, 2);
        gap_armed = 1'b1;
        last_issue_cyc = cyc;
      end else if (a_ack || b_ack) begin
        fail("ack_without_issue");
      end
      if (a_rd_data_v && b_rd_data_v) begin
        fail("both_rd_valid");
      end else if (a_rd_data_v || b_rd_data_v) begin
        if (exp_rd.size() == 0) begin
          fail("unexpected_rd_valid");
        end else begin
          r = exp_rd.pop_front();
          check("rd_owner_is_b", b_rd_data_v, r.id);
          check("rd_data", b_rd_data_v ? b_rd_data : a_rd_data, r.data);
          rd_lat = cyc - last_issue_cyc;
        end
      end
    end
  end

  initial begin
    int   t0;
    bit   cur;
    logic [63:0] d0, d1;
    logic [13:0] aw_addr[5], bw_addr[5];
    logic [63:0] aw_data[5], bw_data[5];

    // reset state
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // contention out of reset: A then B, decoder answers 5 cycles after issue
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    queue_txn(0, 1'b0, 1'b0, 14'h0100, '0);
    queue_txn(1, 1'b0, 1'b0, 14'h0200, '0);
    expect_txn(0, 1'b0, 14'h0100, '0, 5, d0, 1'b1, d0);
    expect_txn(1, 1'b0, 14'h0200, '0, 5, d1, 1'b1, d1);
    fork
      drive_req(0);
      drive_req(1);
    join
    wait_drain();
    check("contention_rd_latency", rd_lat, 6);

    // sustained write contention: strict alternation, one write per 2 cycles
    for (int k = 0; k < 5; k++) begin
      aw_addr[k] = 14'($urandom); aw_data[k] = {$urandom, $urandom};
      bw_addr[k] = 14'($urandom); bw_data[k] = {$urandom, $urandom};
      queue_txn(0, 1'b1, 1'b0, aw_addr[k], aw_data[k]);
      queue_txn(1, 1'b1, 1'b0, bw_addr[k], bw_data[k]);
    end
    cur = !tb_last;
    for (int k = 0; k < 10; k++) begin
      if (!cur) expect_txn(0, 1'b1, aw_addr[k/2], aw_data[k/2], 0, '0, 1'b0, '0);
      else      expect_txn(1, 1'b1, bw_addr[k/2], bw_data[k/2], 0, '0, 1'b0, '0);
      cur = !cur;
    end
    @(negedge clk);
    chk_gap = 1'b1;
    gap_armed = 1'b0;
    fork
      drive_req(0);
      drive_req(1);
    join
    wait_drain();
    chk_gap = 1'b0;

    // single write from A, issued one cycle after the request is seen
    queue_txn(0, 1'b1, 1'b0, 14'h0010, 64'h1122_3344_5566_7788);
    expect_txn(0, 1'b1, 14'h0010, 64'h1122_3344_5566_7788, 0, '0, 1'b0, '0);
    @(negedge clk);
    t0 = cyc;
    drive_req(0);
    check("write_issue_latency", last_issue_cyc - t0, 1);
    wait_drain();

`ifdef MM_ARB_TIMEOUT_EN
    // B read with no timely response: timeout pattern exactly 64 cycles after issue
    d0 = {$urandom, $urandom};
    queue_txn(1, 1'b0, 1'b0, 14'h2040, '0);
    expect_txn(1, 1'b0, 14'h2040, '0, 70, d0, 1'b1, 64'hDEAD_0BAD_0000_2040);
    @(negedge clk);
    drive_req(1);
    wait_drain();
    check("timeout_latency", rd_lat, 64);
    check("timeout_cnt_after_timeout", timeout_cnt, 1);

    // response on the last timer cycle: real data wins, count unchanged
    d1 = {$urandom, $urandom};
    queue_txn(0, 1'b0, 1'b0, 14'h0333, '0);
    expect_txn(0, 1'b0, 14'h0333, '0, TO_CYCLES - 1, d1, 1'b1, d1);
    @(negedge clk);
    drive_req(0);
    wait_drain();
    check("edge_valid_latency", rd_lat, 64);
    check("timeout_cnt_after_edge_valid", timeout_cnt, 1);
`else
    // without the timeout feature a very late response is still delivered
    d0 = {$urandom, $urandom};
    queue_txn(1, 1'b0, 1'b0, 14'h2040, '0);
    expect_txn(1, 1'b0, 14'h2040, '0, 500, d0, 1'b1, d0);
    @(negedge clk);
    drive_req(1);
    wait_drain();
    check("late_resp_latency", rd_lat, 501);
    check("timeout_cnt_disabled", timeout_cnt, 0);
`endif

    // randomized rounds
    for (int n = 0; n < 30; n++) begin
      int   mask;
      bit   first;
      txn_t ta, tb;
      logic [63:0] ra, rb;
      int   da, db;
      mask = $urandom_range(1, 3);
      ta.wr = 1'($urandom_range(0, 1)); ta.rd_also = ta.wr & 1'($urandom_range(0, 1));
      ta.addr = 14'($urandom); ta.data = {$urandom, $urandom};
      tb.wr = 1'($urandom_range(0, 1)); tb.rd_also = tb.wr & 1'($urandom_range(0, 1));
      tb.addr = 14'($urandom); tb.data = {$urandom, $urandom};
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      da = $urandom_range(1, 40); db = $urandom_range(1, 40);
      if (mask[0]) queue_txn(0, ta.wr, ta.rd_also, ta.addr, ta.data);
      if (mask[1]) queue_txn(1, tb.wr, tb.rd_also, tb.addr, tb.data);
      first = (mask == 3) ? !tb_last : (mask == 2);
      for (int j = 0; j < 2; j++) begin
        bit id;
        id = (j == 0) ? first : !first;
        if ((j == 0) || (mask == 3)) begin
          if (!id) expect_txn(0, ta.wr, ta.addr, ta.data, da, ra, 1'b1, ra);
          else     expect_txn(1, tb.wr, tb.addr, tb.data, db, rb, 1'b1, rb);
        end
      end
      @(negedge clk);
      fork
        begin if (mask[0]) drive_req(0); end
        begin if (mask[1]) drive_req(1); end
      join
      wait_drain();
    end

    // reset in the middle of an outstanding read: abandoned, nothing returned
    queue_txn(0, 1'b0, 1'b0, 14'h0777, '0);
    expect_txn(0, 1'b0, 14'h0777, '0, -1, '0, 1'b0, '0);
    @(negedge clk);
    drive_req(0);
    repeat (5) @(negedge clk);
    check("busy_in_wait_rd", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midread_reset");
    tb_last = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    queue_txn(0, 1'b1, 1'b0, 14'h0042, 64'hCAFE_F00D_1234_5678);
    expect_txn(0, 1'b1, 14'h0042, 64'hCAFE_F00D_1234_5678, 0, '0, 1'b0, '0);
    drive_req(0);
    wait_drain();

    check("scoreboard_issue_empty", exp_iss.size(), 0);
    check("scoreboard_rd_empty", exp_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xx02_mm_arbiter.md
Name: xx02_mm_arbiter

Overview:
- Shares the single 14-bit-address, 64-bit-data memory-mapped register bus in front of the xx02 address decoder between two masters.
- Requester A is the PCIe BAR target and has round-robin parity with requester B, the internal debug/sequencer master.
- Issues one transaction at a time, tracks the outstanding read and routes returned data to the owning requester.
- Read timeout keeps a dead decoder slot from hanging either master.

Parameters:
AW, 14, address width
DW, 64, data width
TO_CYCLES, 64, read timeout in clk cycles measured from issue; legal range 4..1023

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
a_addr  in  AW  requester A address
a_wr_en  in  1  A write request, level, held until a_ack
a_rd_en  in  1  A read request, level, held until a_ack
a_wr_data  in  DW  A write data
a_ack  out  1  A request accepted/issued, 1-cycle pulse
a_rd_data  out  DW  A read return data
a_rd_data_v  out  1  A read return valid, 1-cycle pulse
b_addr, b_wr_en, b_rd_en, b_wr_data, b_ack, b_rd_data, b_rd_data_v  same as A, for requester B
m_addr  out  AW  to decoder iMM_ADDR
m_wr_en  out  1  to decoder iMM_WR_EN
m_rd_en  out  1  to decoder iMM_RD_EN
m_wr_data  out  DW  to decoder iMM_WR_DATA
m_rd_data  in  DW  from decoder oMM_RD_DATA
m_rd_data_v  in  1  from decoder oMM_RD_DATA_V
busy  out  1  transaction in flight (state != IDLE)
timeout_cnt  out  16  saturating count of read timeouts

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low.
- Output registration: all outputs registered.
- Reset values: state=IDLE, last_grant=B (so A wins the first tie), all enables/acks/valids 0, m_addr/m_wr_data/rd_data 0, timeout_cnt 0.
- Request definition: requester X requests when x_wr_en|x_rd_en. If both are high, the transaction is a write and the read is ignored.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If no request: stay in IDLE.
  - If exactly one requester requests: grant it.
  - If both request: grant the one not in last_grant.
  - On grant: latch addr, data and type; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - m_wr_en or m_rd_en = 1, with m_addr/m_wr_data held.
  - x_ack = 1 for the granted requester; last_grant updated.
  - Write: next state IDLE.
  - Read: clear the timer; next state WAIT_RD.
- Issue latency: request seen in IDLE at cycle t → m_*_en and ack at t+1.
- Write throughput: one write per 2 cycles maximum.
- m_* outside ISSUE: m_wr_en/m_rd_en = 0; m_addr/m_wr_data hold their last value.
- WAIT_RD, data return:
  - On m_rd_data_v=1: x_rd_data ← m_rd_data and x_rd_data_v=1 next cycle for the owning requester only; next state IDLE.
- WAIT_RD, timeout:
  - Timer counts every cycle, width ceil(log2(TO_CYCLES+1)).
  - Timer == TO_CYCLES-1 with no valid: return {32'hDEAD_0BAD, {(32-AW){0}}, addr} with rd_data_v; timeout_cnt += 1, saturating at 16'hFFFF; next state IDLE.
- Valid and timeout in the same cycle: valid wins; real data is returned and timeout_cnt is unchanged.
- m_rd_data_v outside WAIT_RD (late response after timeout, or spurious): dropped, no x_rd_data_v.
- Requester side: deasserting a request before ack is tolerated; the request simply is not granted. Masters must not change addr/data while requesting.
- Ack/valid relationship: a read's x_ack always precedes its x_rd_data_v by ≥1 cycle.
- Mid-operation reset: returns everything to reset values immediately. The outstanding read is abandoned, with no valid to either requester.

Optional Feature:
MM_ARB_TIMEOUT_EN
- Defined: timeout logic as above.
- Undefined: WAIT_RD waits indefinitely for m_rd_data_v; timer removed; timeout_cnt tied to 0; TO_CYCLES unused.

Decomposition:
- Package xx02_mm_arb_pkg: state enum (IDLE, ISSUE, WAIT_RD), timeout data pattern constant 32'hDEAD_0BAD, requester-id typedef (REQ_A=0, REQ_B=1).
- Sub-module xx02_rr_arb2: 2-way round-robin grant from req[1:0] and last_grant.
- FSM, timer and data routing stay in the top module.

Test Plan:
- Single writes: A write addr 14'h0010 data 64'h1122_3344_5566_7788 → one-cycle m_wr_en at t+1 with same addr/data; a_ack pulse; b_ack stays 0.
- Contention: A and B both read simultaneously out of reset; decoder returns data 5 cycles after issue → A issued first and gets its data, then B issued; each x_rd_data_v only to its owner.
- Sustained contention: both hold write requests for 10 transactions → strict A,B,A,B alternation; one m_wr_en every 2 cycles.
- Timeout: B reads 14'h2040 with no decoder response, TO_CYCLES=64 → b_rd_data=64'hDEAD_0BAD_0000_2040 exactly 64 cycles after issue; timeout_cnt=1. A late m_rd_data_v at cycle 70 is dropped.
- Valid on the timeout cycle: m_rd_data_v arrives on cycle TO_CYCLES-1 → real data returned; timeout_cnt unchanged. With MM_ARB_TIMEOUT_EN undefined, a response after 500 cycles is still delivered.
- Reset mid-read: assert rst_n low during WAIT_RD → all outputs 0 asynchronously; no rd_data_v after release; next A request is served normally.
